pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer: one outstanding instruction fetch, a single held slot
// toward decode, branch squashing and halt. Trap support is built with PC_SEQUENCER_TRAP_EN.
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap,
  output logic             halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;
  localparam logic [1:0] HALT   = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc_next;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_instr_pc;

  logic             w_trap;
  logic             w_jump;
  logic [WIDTH-1:0] w_tgt;

`ifdef PC_SEQUENCER_TRAP_EN
  assign w_trap = trap;
`else
  assign w_trap = 1'b0 & trap;
`endif

  // Trap outranks redirect; both share the same squash machinery.
  assign w_jump = w_trap | redirect;
  assign w_tgt  = w_trap ? TRAP_VECTOR : redirect_pc;

  assign imem_req    = (r_state == FETCH) || (r_state == SQUASH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = (r_state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_VECTOR;
      r_pc_next  <= RESET_VECTOR;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_jump && imem_ack) begin
            r_pc <= w_tgt;
          end else if (w_jump) begin
            r_pc_next <= w_tgt;
            r_state   <= SQUASH;
          end else if (imem_ack) begin
            r_instr    <= imem_data;
            r_instr_pc <= r_pc;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_jump) begin
            r_pc    <= w_tgt;
            r_state <= FETCH;
          end else if (instr_ready) begin
            r_pc    <= r_instr_pc + WIDTH'(1);
            r_state <= (r_instr == 32'hFFFF_FFFF) ? HALT : FETCH;
          end
        end
        SQUASH: begin
          // The stale response still has to drain before the target is fetched.
          if (imem_ack) begin
            r_pc    <= w_jump ? w_tgt : r_pc_next;
            r_state <= FETCH;
          end else if (w_jump) begin
            r_pc_next <= w_tgt;
          end
        end
        default: begin
          if (w_trap) begin
            r_pc    <= TRAP_VECTOR;
            r_state <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; trap expectations follow PC_SEQUENCER_TRAP_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instr, instr_pc;
  logic        imem_ack, instr_ready, redirect, trap;
  logic [31:0] imem_data, redirect_pc;

  logic        req2, valid2, halted2;
  logic [31:0] addr2, instr2, ipc2;
  logic        ack2, ready2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .trap(trap), .halted(halted)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_data(32'h1234_5678), .instr_valid(valid2),
    .instr(instr2), .instr_pc(ipc2), .instr_ready(ready2),
    .redirect(1'b0), .redirect_pc(32'h0), .trap(1'b0), .halted(halted2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_trap_addr;

  initial begin
    rst_n = 1'b0; imem_ack = 0; imem_data = 0; instr_ready = 0;
    redirect = 0; redirect_pc = 0; trap = 0; ack2 = 0; ready2 = 0;
    step();
    check("rst_req", 32'(imem_req), 1);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    rst_n = 1'b1;

    // sequential fetch 0..6, ack after one waiting cycle
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("seq_addr_wait%0d", k), imem_addr, 32'(k));
      check("seq_req", 32'(imem_req), 1);
      imem_ack = 1; imem_data = 32'h1000 + 32'(k);
      step();
      imem_ack = 0;
      check($sformatf("seq_ipc%0d", k), instr_pc, 32'(k));
      check($sformatf("seq_instr%0d", k), instr, 32'h1000 + 32'(k));
      check("seq_valid", 32'(instr_valid), 1);
      check("seq_req_hold", 32'(imem_req), 0);
      if (k == 5) begin
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall_ipc", instr_pc, 5);
          check("stall_instr", instr, 32'h1005);
          check("stall_valid", 32'(instr_valid), 1);
          check("stall_req", 32'(imem_req), 0);
        end
      end
      instr_ready = 1;
      step();
      instr_ready = 0;
      #0;
      // step() at loop top would add a cycle; undo by checking here then continuing
      check($sformatf("seq_next_addr%0d", k), imem_addr, 32'(k + 1));
    end

    // redirect while fetch of 7 waits two cycles
    check("redir_pre_addr", imem_addr, 7);
    redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    check("squash_addr0", imem_addr, 7);
    check("squash_req0", 32'(imem_req), 1);
    check("squash_valid0", 32'(instr_valid), 0);
    step();
    check("squash_addr1", imem_addr, 7);
    imem_ack = 1; imem_data = 32'hDEAD_0007;
    step();
    imem_ack = 0;
    check("squash_valid2", 32'(instr_valid), 0);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_req", 32'(imem_req), 1);

    // redirect in HOLD drops the held instruction
    imem_ack = 1; imem_data = 32'h0000_0040;
    step();
    imem_ack = 0;
    check("hold40_valid", 32'(instr_valid), 1);
    redirect = 1; redirect_pc = 32'h80;
    step();
    redirect = 0;
    check("hold_redir_valid", 32'(instr_valid), 0);
    check("hold_redir_addr", imem_addr, 32'h80);

    // trap and redirect together, with ack in FETCH
`ifdef PC_SEQUENCER_TRAP_EN
    exp_trap_addr = 32'h4;
`else
    exp_trap_addr = 32'h90;
`endif
    trap = 1; redirect = 1; redirect_pc = 32'h90; imem_ack = 1; imem_data = 32'hBAD0_0080;
    step();
    trap = 0; redirect = 0; imem_ack = 0;
    check("prio_addr", imem_addr, exp_trap_addr);
    check("prio_valid", 32'(instr_valid), 0);

    // halt instruction
    imem_ack = 1; imem_data = 32'hFFFF_FFFF;
    step();
    imem_ack = 0;
    check("halt_instr", instr, 32'hFFFF_FFFF);
    instr_ready = 1;
    step();
    instr_ready = 0;
    check("halt_halted", 32'(halted), 1);
    check("halt_req", 32'(imem_req), 0);
    check("halt_valid", 32'(instr_valid), 0);
    redirect = 1; redirect_pc = 32'h55;
    step();
    redirect = 0;
    check("halt_redir_ignored", 32'(halted), 1);
    trap = 1;
    step();
    trap = 0;
`ifdef PC_SEQUENCER_TRAP_EN
    check("halt_trap_halted", 32'(halted), 0);
    check("halt_trap_addr", imem_addr, 32'h4);
    check("halt_trap_req", 32'(imem_req), 1);
`else
    check("halt_trap_ignored", 32'(halted), 1);
    check("halt_trap_req", 32'(imem_req), 0);
`endif

    // asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    check("async_halted", 32'(halted), 0);
    check("async_addr", imem_addr, 0);
    check("async_instr", instr, 0);
    check("async_ipc", instr_pc, 0);
    check("async_req", 32'(imem_req), 1);
    check("wrap_rst_addr", addr2, 32'hFFFF_FFFF);
    step();
    rst_n = 1'b1;

    // wrap: RESET_VECTOR all-ones, second fetch at 0
    step();
    check("wrap_first", addr2, 32'hFFFF_FFFF);
    ack2 = 1;
    step();
    ack2 = 0;
    check("wrap_ipc", ipc2, 32'hFFFF_FFFF);
    ready2 = 1;
    step();
    ready2 = 0;
    check("wrap_second", addr2, 32'h0);
    check("wrap_req", 32'(req2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
